// File: rtl/sub_pkg.sv
// Shared types and width bounds for the bit-serial subtractor.
package sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/full_sub.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow-out.
module full_sub (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = x_i ^ y_i ^ bin_i;
    assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial A - B - bin, LSB first, one bit per clock through a single full_sub cell.
// Results are loaded only on the MSB edge, so the outputs never show partial values.
module serial_sub
    import sub_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("serial_sub: WIDTH=%0d outside legal range %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] d_sr_q;
    logic [WIDTH-1:0] d_sr_d;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_q;
    logic             bout_q;
    logic             ovf_q;
    logic             done_q;
    logic             cell_d;
    logic             cell_bo;

    full_sub u_cell (
        .x_i    (a_sr_q[0]),
        .y_i    (b_sr_q[0]),
        .bin_i  (borrow_q),
        .d_o    (cell_d),
        .bout_o (cell_bo)
    );

    // Each new difference bit enters at the MSB, so after WIDTH shifts bit 0 holds the LSB.
    assign d_sr_d = {cell_d, d_sr_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            d_sr_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        borrow_q <= bin;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    d_sr_q   <= d_sr_d;
                    borrow_q <= cell_bo;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // borrow_q still holds the borrow into the MSB here.
                        diff_q  <= d_sr_d;
                        bout_q  <= cell_bo;
                        ovf_q   <= borrow_q ^ cell_bo;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
